// File: rtl/booth_r4_ctrl.sv
`default_nettype none
//============================================================================
// Module      : booth_r4_ctrl
// Description : Control sequencer for a radix-4 Booth multiplier datapath.
//               Walks INIT -> (DECODE [-> ADD] -> SHIFT) x ITER -> OUT and
//               issues one-cycle strobes to the accumulator A, the
//               multiplier register Q, the parallel adder and the result
//               bus. Each iteration's operation comes from the Booth
//               triplet {Q[1],Q[0],Q[-1]}.
//
// Ports       :
//   clk        in   system clock, all state changes on posedge
//   reset      in   synchronous active-high reset
//   start      in   begin a multiplication (sampled only in IDLE)
//   booth_bits in   {Q[1],Q[0],Q[-1]} (sampled only in DECODE)
//   c0         out  clear A and Q[-1]
//   c1         out  load M and Q from the operand inputs
//   c2         out  write adder result into A
//   c3         out  adder operand select: 1 = 2M, 0 = M (only with c2)
//   c4         out  adder mode: 1 = subtract, 0 = add (only with c2)
//   c5         out  arithmetic right shift of {A,Q,Q[-1]} by 2
//   c6         out  drive product {A,Q} onto the result bus
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse coincident with c6
//   cnt        out  current iteration index
//
// Revision    : 1.0 - initial release
//============================================================================
module booth_r4_ctrl #(
    parameter int N = 8,
    localparam int ITER = N / 2,
    localparam int CNT_W = $clog2(N / 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       booth_bits,
    output logic             c0,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic             c4,
    output logic             c5,
    output logic             c6,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_DECODE = 3'd2,
        S_ADD    = 3'd3,
        S_SHIFT  = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sel_2m;
    logic             w_sel_2m_nxt;
    logic             r_sub;
    logic             w_sub_nxt;

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sel_2m <= 1'b0;
            r_sub    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel_2m <= w_sel_2m_nxt;
            r_sub    <= w_sub_nxt;
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_2m_nxt = r_sel_2m;
        w_sub_nxt    = r_sub;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_INIT;
                end
            end

            S_INIT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_DECODE;
            end

            S_DECODE: begin
                // Radix-4 Booth recoding of the triplet into a digit in
                // {-2,-1,0,+1,+2}; the digit is captured so the ADD cycle
                // drives c3/c4 from registered state only.
                case (booth_bits)
                    3'b001, 3'b010: begin
                        w_sel_2m_nxt = 1'b0;
                        w_sub_nxt    = 1'b0;
                        w_state_nxt  = S_ADD;
                    end
                    3'b011: begin
                        w_sel_2m_nxt = 1'b1;
                        w_sub_nxt    = 1'b0;
                        w_state_nxt  = S_ADD;
                    end
                    3'b100: begin
                        w_sel_2m_nxt = 1'b1;
                        w_sub_nxt    = 1'b1;
                        w_state_nxt  = S_ADD;
                    end
                    3'b101, 3'b110: begin
                        w_sel_2m_nxt = 1'b0;
                        w_sub_nxt    = 1'b1;
                        w_state_nxt  = S_ADD;
                    end
                    default: begin
                        // 000 / 111: digit zero, nothing to accumulate
                        w_sel_2m_nxt = 1'b0;
                        w_sub_nxt    = 1'b0;
                        w_state_nxt  = S_SHIFT;
                    end
                endcase
            end

            S_ADD: begin
                w_state_nxt = S_SHIFT;
            end

            S_SHIFT: begin
                // cnt is held on the final iteration so it never passes
                // ITER-1; it restarts only through INIT.
                if (r_cnt == c_LAST_ITER) begin
                    w_state_nxt = S_OUT;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end

            S_OUT: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Outputs: decoded purely from registered state
    //------------------------------------------------------------------------
    assign c0   = (r_state == S_INIT);
    assign c1   = (r_state == S_INIT);
    assign c2   = (r_state == S_ADD);
    assign c3   = (r_state == S_ADD) & r_sel_2m;
    assign c4   = (r_state == S_ADD) & r_sub;
    assign c5   = (r_state == S_SHIFT);
    assign c6   = (r_state == S_OUT);
    assign done = (r_state == S_OUT);
    assign busy = (r_state != S_IDLE);
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_booth_r4_ctrl
// Description : Self-checking bench for booth_r4_ctrl. A cycle-level
//               reference model (a queue of expected phases per
//               multiplication) checks every cycle; a vector table, a few
//               hand-written sequences and a behavioural A/Q/M datapath
//               cover latency, start handling, mid-op reset and products.
// Revision    : 1.0 - initial release
//============================================================================
module tb_booth_r4_ctrl;

    localparam int N     = 8;
    localparam int ITER  = N / 2;
    localparam int CNT_W = $clog2(ITER);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       booth_bits;
    logic [2:0]       bb_drv;
    logic             c0, c1, c2, c3, c4, c5, c6, busy, done;
    logic [CNT_W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_r4_ctrl #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .booth_bits (booth_bits),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .c4         (c4),
        .c5         (c5),
        .c6         (c6),
        .busy       (busy),
        .done       (done),
        .cnt        (cnt)
    );

    //------------------------------------------------------------------------
    // Behavioural datapath: A is N+2 bits so +-2M never overflows
    //------------------------------------------------------------------------
    logic                 use_dp;
    logic [N-1:0]         m_in, q_in;
    logic signed [N+1:0]  dp_a;
    logic [N-1:0]         dp_q, dp_m;
    logic                 dp_q1;
    logic signed [N+1:0]  w_m_ext, w_addend;
    logic [2*N+2:0]       w_shifted;

    assign w_m_ext    = {{2{dp_m[N-1]}}, dp_m};
    assign w_addend   = c3 ? (w_m_ext <<< 1) : w_m_ext;
    assign w_shifted  = $signed({dp_a, dp_q, dp_q1}) >>> 2;
    assign booth_bits = use_dp ? {dp_q[1:0], dp_q1} : bb_drv;

    always @(posedge clk) begin
        if (c1) begin
            dp_m <= m_in;
            dp_q <= q_in;
        end
        if (c0) begin
            dp_a  <= '0;
            dp_q1 <= 1'b0;
        end else if (c2) begin
            dp_a <= c4 ? (dp_a - w_addend) : (dp_a + w_addend);
        end else if (c5) begin
            {dp_a, dp_q, dp_q1} <= w_shifted;
        end
    end

    //------------------------------------------------------------------------
    // Reference model: queue of the phases still to come in the current op
    //------------------------------------------------------------------------
    localparam int K_INIT = 1, K_DEC = 2, K_ADD = 3, K_SHIFT = 4, K_OUT = 5;
    typedef struct {
        int kind;
        int idx;
        bit sel;
        bit sub;
    } tok_t;
    tok_t exp_q[$];
    int   last_cnt = 0;

    task automatic model_update(input logic s, input logic r, input logic [2:0] bb);
        tok_t h, t;
        int   d;
        if (r) begin
            exp_q.delete();
            last_cnt = 0;
        end else if (exp_q.size() == 0) begin
            if (s) begin
                t = '{K_INIT, 0, 1'b0, 1'b0};
                exp_q.push_back(t);
                for (int i = 0; i < ITER; i++) begin
                    t = '{K_DEC, i, 1'b0, 1'b0};
                    exp_q.push_back(t);
                    t = '{K_SHIFT, i, 1'b0, 1'b0};
                    exp_q.push_back(t);
                end
                t = '{K_OUT, ITER - 1, 1'b0, 1'b0};
                exp_q.push_back(t);
            end
        end else begin
            h = exp_q.pop_front();
            if (h.kind == K_DEC) begin
                d = -2 * int'(bb[2]) + int'(bb[1]) + int'(bb[0]);
                if (d != 0) begin
                    t = '{K_ADD, h.idx, (d == 2 || d == -2), (d < 0)};
                    exp_q.push_front(t);
                end
            end else if (h.kind == K_OUT) begin
                last_cnt = ITER - 1;
            end
        end
    endtask

    // bit order: c0 c1 c2 c3 c4 c5 c6 busy done
    function automatic logic [8:0] model_vec();
        tok_t h;
        if (exp_q.size() == 0) return 9'b0;
        h = exp_q[0];
        case (h.kind)
            K_INIT:  return 9'b110000010;
            K_DEC:   return 9'b000000010;
            K_ADD:   return {2'b00, 1'b1, h.sel, h.sub, 4'b0010};
            K_SHIFT: return 9'b000001010;
            default: return 9'b000000111;
        endcase
    endfunction

    function automatic int model_cnt();
        if (exp_q.size() == 0) return last_cnt;
        if (exp_q[0].kind == K_INIT) return last_cnt;
        return exp_q[0].idx;
    endfunction

    function automatic logic [8:0] dut_vec();
        return {c0, c1, c2, c3, c4, c5, c6, busy, done};
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    // One clock: drive inputs after negedge, advance model at posedge,
    // compare at the next negedge.
    task automatic step(input logic s, input logic r, input logic [2:0] bb);
        logic       s_s, r_s;
        logic [2:0] bb_s;
        start  = s;
        reset  = r;
        bb_drv = bb;
        #1;
        s_s  = start;
        r_s  = reset;
        bb_s = booth_bits;
        @(posedge clk);
        model_update(s_s, r_s, bb_s);
        @(negedge clk);
        check("model_strobes", int'(dut_vec()), int'(model_vec()));
        check("model_cnt", int'(cnt), model_cnt());
    endtask

    // Runs one op from IDLE; latency is the spec's k+L offset of done.
    task automatic run_op(input logic [2:0] bb, output int lat, output int adds,
                          output int c34, output int stray);
        int j;
        lat = -1; adds = 0; c34 = -1; stray = 0; j = 0;
        step(1'b1, 1'b0, bb);
        while (!done && j < 40) begin
            step(1'b0, 1'b0, bb);
            j++;
            if (c2) begin
                adds++;
                c34 = {c3, c4};
            end else if (c3 || c4) begin
                stray++;
            end
        end
        if (done) lat = j + 1;
        step(1'b0, 1'b0, bb);
    endtask

    task automatic mul(input logic [N-1:0] m, input logic [N-1:0] q,
                       output logic [2*N-1:0] p, output logic ok);
        int j;
        m_in = m;
        q_in = q;
        j = 0;
        step(1'b1, 1'b0, 3'b000);
        while (!c6 && j < 40) begin
            step(1'b0, 1'b0, 3'b000);
            j++;
        end
        ok = c6;
        p  = {dp_a[N-1:0], dp_q};
        step(1'b0, 1'b0, 3'b000);
    endtask

    typedef struct {
        logic       s;
        logic       r;
        logic [2:0] bb;
        logic [8:0] ev;
        int         ec;
    } vec_t;

    initial begin
        vec_t          tbl[12];
        int            lat, adds, c34, stray;
        logic [2:0]    bsel[6];
        int            e_c34[6];
        int            e_lat[6];
        logic [2*N-1:0] p;
        logic          ok;
        logic [N-1:0]  rm, rq;
        int            pe;

        start = 1'b0; reset = 1'b1; bb_drv = 3'b000; use_dp = 1'b0;
        m_in = '0; q_in = '0;

        // Vector table: reset, then one all-no-op multiplication
        tbl[0]  = '{1'b0, 1'b1, 3'b000, 9'b000000000, 0};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 9'b110000010, 0};
        for (int i = 0; i < ITER; i++) begin
            tbl[2 + 2*i] = '{1'b0, 1'b0, 3'b000, 9'b000000010, i};
            tbl[3 + 2*i] = '{1'b0, 1'b0, 3'b000, 9'b000001010, i};
        end
        tbl[10] = '{1'b0, 1'b0, 3'b000, 9'b000000111, ITER - 1};
        tbl[11] = '{1'b0, 1'b0, 3'b000, 9'b000000000, ITER - 1};

        @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            step(tbl[j].s, tbl[j].r, tbl[j].bb);
            check("tbl_strobes", int'(dut_vec()), int'(tbl[j].ev));
            check("tbl_cnt", int'(cnt), tbl[j].ec);
        end

        // Per-pattern runs: latency, add count, (c3,c4) in ADD, no stray c3/c4
        bsel  = '{3'b011, 3'b100, 3'b101, 3'b001, 3'b110, 3'b111};
        e_c34 = '{2, 3, 1, 0, 1, -1};
        e_lat = '{14, 14, 14, 14, 14, 10};
        for (int i = 0; i < 6; i++) begin
            run_op(bsel[i], lat, adds, c34, stray);
            check("pat_latency", lat, e_lat[i]);
            check("pat_adds", adds, (e_lat[i] == 14) ? ITER : 0);
            check("pat_c3c4", c34, e_c34[i]);
            check("pat_stray_c3c4", stray, 0);
        end

        // Reset during an ADD cycle
        begin
            int j;
            j = 0;
            step(1'b1, 1'b0, 3'b011);
            while (!c2 && j < 10) begin
                step(1'b0, 1'b0, 3'b011);
                j++;
            end
            check("rst_reached_add", int'(c2), 1);
            step(1'b0, 1'b1, 3'b011);
            check("rst_strobes", int'(dut_vec()), 0);
            check("rst_cnt", int'(cnt), 0);
            run_op(3'b011, lat, adds, c34, stray);
            check("rst_then_latency", lat, 14);
        end

        // Mid-op start pulse ignored; held start restarts after one IDLE cycle
        begin
            int j;
            step(1'b1, 1'b0, 3'b011);
            for (int r = 1; r <= 15; r++) begin
                step((r == 3) || (r >= 12), 1'b0, 3'b011);
                if (r == 12) check("hold_no_early_done", int'(done), 0);
                if (r == 13) check("hold_done_k14", int'(done), 1);
                if (r == 14) check("hold_idle_k15", int'(busy), 0);
                if (r == 15) check("hold_init_k16", int'(c0 & c1), 1);
            end
            j = 0;
            while (busy && j < 30) begin
                step(1'b0, 1'b0, 3'b011);
                j++;
            end
            check("hold_drained", int'(busy), 0);
        end

        // Integration with the behavioural datapath
        use_dp = 1'b1;
        mul(8'hF9, 8'h0D, p, ok);
        check("dp_done_m7x13", int'(ok), 1);
        check("dp_prod_m7x13", int'(p), 16'hFFA5);
        mul(8'h80, 8'h80, p, ok);
        check("dp_done_80x80", int'(ok), 1);
        check("dp_prod_80x80", int'(p), 16'h4000);
        for (int i = 0; i < 20; i++) begin
            rm = N'($urandom);
            rq = N'($urandom);
            pe = $signed(rm) * $signed(rq);
            mul(rm, rq, p, ok);
            check("dp_rand_prod", int'(p), pe & 32'hFFFF);
        end
        use_dp = 1'b0;

        // Random start/reset/booth_bits against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) == 0, ($urandom % 60) == 0, 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/booth_r4_ctrl.md
Name: booth_r4_ctrl

Overview:
Control sequencer for the radix-4 Booth multiplier datapath. It issues one-cycle strobes c0..c6 to the accumulator A, the multiplier register Q, the parallel adder and the output bus. It decides each iteration's operation from the three Booth bits {Q[1],Q[0],Q[-1]} supplied by the Q register. It sits directly upstream of the accumulator and adder: every load, add/sub and arithmetic shift they perform is triggered by this block.

Parameters:
N, 8, operand width in bits; must be even and >= 4.
ITER, N/2, number of radix-4 iterations (derived; not overridden).
CNT_W, $clog2(N/2), iteration counter width (derived).

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  request to begin a multiplication; sampled only in IDLE.
booth_bits  input  3  {Q[1],Q[0],Q[-1]} from the Q register; sampled only in DECODE.
c0  output  1  clear A and Q[-1].
c1  output  1  load M and Q from the operand inputs.
c2  output  1  adder result is written into A.
c3  output  1  adder operand select: 1 = 2M, 0 = M; valid only with c2.
c4  output  1  adder mode: 1 = subtract, 0 = add; valid only with c2.
c5  output  1  arithmetic right shift of {A,Q,Q[-1]} by 2 bits.
c6  output  1  drive the product {A,Q} onto the result bus.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse, coincident with c6.
cnt  output  CNT_W  current iteration index.

Behaviour:
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Reset (synchronous, checked first, overrides everything including mid-operation): state=IDLE, cnt=0, stored sel_2m=0, stored sub=0. All c0..c6, busy and done = 0 from the next cycle.
- States: IDLE, INIT, DECODE, ADD, SHIFT, OUT.
- IDLE: all strobes 0. If start=1 at a posedge, go to INIT.
- INIT: one cycle. c0=1 and c1=1 together; cnt<=0. Go to DECODE.
- DECODE: one cycle, no strobes. Register the Booth recoding of booth_bits:
  - 000, 111 -> no operation; go to SHIFT.
  - 001, 010 -> +M (sel_2m=0, sub=0); go to ADD.
  - 011 -> +2M (sel_2m=1, sub=0); go to ADD.
  - 100 -> -2M (sel_2m=1, sub=1); go to ADD.
  - 101, 110 -> -M (sel_2m=0, sub=1); go to ADD.
- ADD: one cycle. c2=1, c3=sel_2m, c4=sub. Go to SHIFT.
- SHIFT: one cycle. c5=1.
  - If cnt==ITER-1: go to OUT; cnt is held.
  - Otherwise: cnt<=cnt+1 and go to DECODE.
- OUT: one cycle. c6=1, done=1. Go to IDLE.
- c3 and c4 are 0 in every state except ADD.
- At most one of c2, c5, c6 is high in any cycle. c0 and c1 are high only in INIT.
- Latency: start is sampled at edge k and INIT occupies cycle k+1.
  - Every iteration a no-op: done in cycle k+10.
  - Every iteration an add: done in cycle k+14.
  - General case: done in cycle k+2+2*ITER+(number of add iterations).
- start while busy=1 is ignored and never queued. If start is held high, the next INIT follows one IDLE cycle after OUT.
- booth_bits is ignored outside DECODE; changes in any other state have no effect.
- cnt wraps only through INIT; it never exceeds ITER-1.

Test Plan:
1. Reset, then start pulse with booth_bits=000 held -> c0=c1=1 in cycle k+1; then (DECODE, SHIFT) x4 with c2 never high; c6=done=1 only in cycle k+10; busy low at k+11.
2. booth_bits=011 held -> each of 4 iterations shows c2=1, c3=1, c4=0, followed by c5=1; done in cycle k+14; cnt steps 0,1,2,3.
3. One run each with booth_bits 100, 101, 001 -> in ADD cycles, (c3,c4) = (1,1), (0,1), (0,0) respectively; c3=c4=0 in all other cycles.
4. reset asserted during an ADD cycle -> next cycle all strobes 0, busy=0, cnt=0. A subsequent start gives a full, normal sequence.
5. start pulsed at k+3 of a running op, then held high continuously from k+12 -> mid-op pulse ignored; done at k+14 (op uses booth_bits=011); one IDLE cycle; new INIT in cycle k+16.
6. Integration with behavioural A/Q/M and adder models: M=0xF9 (-7), Q=0x0D (13) -> when c6 is high, {A[7:0],Q} = 16'hFFA5 (-91). Also M=0x80, Q=0x80 -> 16'h4000.
